activation_cache: RTL and testbench
===================================

ACTIVATION_CACHE -- requirements
Module: activation_cache

Interface
REQ-001 Parameter W, default 16, bit width of each element (fixed point, 4 integer bits, 12 fractional bits).
REQ-002 Parameter D, default 4, number of elements in each packed sample.
REQ-003 Parameter DILATION, default 4, delay in samples between the two output taps; a power of 2, at least 2.
REQ-004 Port clk, input, 1 bit, the single clock; all state SHALL change on the rising edge only.
REQ-005 Port rst_n, input, 1 bit, reset, asynchronous and active-low.
REQ-006 Port inp_v, input, 1 bit, upstream layer valid; held high after the result is ready, until the upstream block is reset.
REQ-007 Port packed_in, input, signed D*W bits, upstream result; element 0 in the MSBs.
REQ-008 Port packed_out_a, output, signed D*W bits, sample from DILATION accepted samples ago; element 0 in the MSBs.
REQ-009 Port packed_out_b, output, signed D*W bits, most recently accepted sample.
REQ-010 Port out_v, output, 1 bit, one-cycle pulse: both taps are valid.
REQ-011 Port overrun, output, 1 bit, sticky flag: an input edge was dropped.

Function
REQ-012 An accept event SHALL occur when the state is IDLE, inp_v is 1, and the registered previous value of inp_v is 0 (rising-edge detect).
REQ-013 The previous-inp_v register SHALL update every cycle, in every state.
REQ-014 States, encoded as 2 bits:
- IDLE -> CAPTURE on an accept event.
- CAPTURE -> READ, unconditional.
- READ -> WRITE, unconditional.
- WRITE -> IDLE, unconditional.
REQ-015 CAPTURE SHALL register packed_in into an internal hold register.
REQ-016 READ SHALL load packed_out_a from ring[wr_ptr] and load packed_out_b from the hold register.
REQ-017 WRITE SHALL store the hold register into ring[wr_ptr] and advance wr_ptr by 1, wrapping from DILATION-1 to 0.
REQ-018 WRITE SHALL assert out_v for exactly the following cycle (subject to REQ-025).
REQ-019 Latency: if the accept edge is clock edge k, out_v SHALL be high between edges k+3 and k+4 and low otherwise.
REQ-020 packed_out_a and packed_out_b SHALL hold their values until the next READ state.
REQ-021 The ring SHALL have DILATION entries of D*W bits each; wr_ptr SHALL be log2(DILATION) bits wide.
REQ-022 No arithmetic SHALL be performed; data SHALL pass through bit-exact.
REQ-023 An inp_v rising edge seen while the state is not IDLE SHALL be dropped and SHALL set overrun to 1 until reset.
REQ-024 inp_v held high for many cycles SHALL produce exactly one accept event.

Reset
REQ-025 While rst_n is 0, the block SHALL immediately set:
- state to IDLE and wr_ptr to 0;
- out_v to 0 and overrun to 0;
- the previous-inp_v register to 0;
- the fill counter to 0;
- every ring entry, the hold register, packed_out_a and packed_out_b to all zeros.
REQ-026 Reset mid-operation SHALL abandon the sample in flight; no out_v pulse SHALL follow for it.
REQ-027 If inp_v is already high when rst_n deasserts, the first clock edge SHALL count as an accept event.

Configuration
REQ-028 The macro ACTIVATION_CACHE_PRIME_EN controls warm-up.
- When defined: a fill counter (saturating at DILATION) SHALL suppress out_v for the first DILATION accepted samples after reset. Those samples SHALL still be written to the ring, and packed_out_a/packed_out_b SHALL still update.
- When undefined: out_v SHALL pulse for every accepted sample, and packed_out_a SHALL be zero until DILATION samples have been written.

Verification
REQ-029 All scenarios use W=16, D=2, DILATION=2, with the macro undefined unless stated.
REQ-030 Accept four sample values at 16-cycle spacing, with inp_v pulsed low then high for each: s0 = {0x1000, 0xF000}, then s1, s2, s3.
- Required taps (out_a, out_b): (0, s0), (0, s1), (s0, s2), (s1, s3).
REQ-031 Raise inp_v at edge 10 and hold it high for 50 cycles -> exactly one out_v pulse, high between edges 13 and 14.
REQ-032 Give a second rising edge 2 cycles after the first accept -> it is dropped, overrun=1, and out_v pulses only once.
REQ-033 Drive rst_n low during READ -> out_v stays 0, all outputs become zero, and wr_ptr returns to 0.
REQ-034 With ACTIVATION_CACHE_PRIME_EN defined, accept s0..s3 -> no out_v for s0 or s1; pulses for s2 and s3 with taps (s0, s2) and (s1, s3).
REQ-035 Hold inp_v high through rst_n deassertion with packed_in = {0x7FFF, 0x8000} -> one pulse at latency 3 with out_b = {0x7FFF, 0x8000}.

Source files
------------

// File: rtl/activation_cache.sv
// activation_cache: keeps the last DILATION packed activation samples in a
// ring and presents two taps per accepted sample -- the sample from
// DILATION accepts ago (packed_out_a) and the newest one (packed_out_b).
// A new sample is accepted on each rising edge of inp_v seen while idle.
// Each accepted sample walks IDLE -> CAPTURE -> READ -> WRITE -> IDLE.
// If an inp_v rising edge arrives while busy, it is dropped and the
// sticky overrun flag is set.
// Optional warm-up: define ACTIVATION_CACHE_PRIME_EN to hide out_v for the
// first DILATION samples after reset, while the ring is still filling.
module activation_cache #(
    parameter int W        = 16,
    parameter int D        = 4,
    parameter int DILATION = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inp_v,
    input  logic signed [D*W-1:0] packed_in,
    output logic signed [D*W-1:0] packed_out_a,
    output logic signed [D*W-1:0] packed_out_b,
    output logic                  out_v,
    output logic                  overrun
);

    localparam int PW = $clog2(DILATION);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        READ    = 2'd2,
        WRITE   = 2'd3
    } state_t;

    state_t            state;
    state_t            next_state;
    logic              inp_v_prev;
    logic              inp_rise;
    logic              accept;
    logic [D*W-1:0]    hold;
    logic [D*W-1:0]    ring [DILATION];
    logic [PW-1:0]     wr_ptr;
    logic              pulse_en;

    assign inp_rise = inp_v && !inp_v_prev;
    assign accept   = (state == IDLE) && inp_rise;

`ifdef ACTIVATION_CACHE_PRIME_EN
    localparam int FW = $clog2(DILATION + 1);

    logic [FW-1:0] fill_cnt;

    // Count accepted samples after reset, stopping at DILATION, so out_v
    // stays hidden until the far tap holds real data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_cnt <= '0;
        end else if (state == WRITE && fill_cnt != FW'(DILATION)) begin
            fill_cnt <= fill_cnt + 1'b1;
        end
    end

    assign pulse_en = (fill_cnt == FW'(DILATION));
`else
    assign pulse_en = 1'b1;
`endif

    // Register the current state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Choose the next state: only an accept leaves IDLE. The other states
    // always advance to the next one.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (accept) next_state = CAPTURE;
            CAPTURE: next_state = READ;
            READ:    next_state = WRITE;
            WRITE:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath: edge-detect history, hold register, output taps, ring
    // write-back with pointer wrap, valid pulse and sticky overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inp_v_prev   <= 1'b0;
            hold         <= '0;
            packed_out_a <= '0;
            packed_out_b <= '0;
            wr_ptr       <= '0;
            out_v        <= 1'b0;
            overrun      <= 1'b0;
            for (int i = 0; i < DILATION; i++) begin
                ring[i] <= '0;
            end
        end else begin
            inp_v_prev <= inp_v;
            out_v      <= (state == WRITE) && pulse_en;
            if (inp_rise && state != IDLE) begin
                overrun <= 1'b1;
            end
            if (state == CAPTURE) begin
                hold <= packed_in;
            end
            if (state == READ) begin
                packed_out_a <= ring[wr_ptr];
                packed_out_b <= hold;
            end
            if (state == WRITE) begin
                ring[wr_ptr] <= hold;
                wr_ptr <= (wr_ptr == PW'(DILATION - 1)) ? '0 : wr_ptr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_activation_cache.sv
// tb_activation_cache: directed test bench for activation_cache with
// W=16, D=2, DILATION=2. Each task drives one scenario and checks its
// results directly against hand-computed values. When
// ACTIVATION_CACHE_PRIME_EN is defined, the bench expects no out_v pulse
// for the warm-up samples.
module tb_activation_cache;

    localparam int W   = 16;
    localparam int D   = 2;
    localparam int DIL = 2;

`ifdef ACTIVATION_CACHE_PRIME_EN
    localparam bit PRIME = 1'b1;
`else
    localparam bit PRIME = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  inp_v = 1'b0;
    logic signed [D*W-1:0] packed_in = '0;
    logic signed [D*W-1:0] packed_out_a;
    logic signed [D*W-1:0] packed_out_b;
    logic                  out_v;
    logic                  overrun;

    int checks = 0;
    int failures = 0;

    activation_cache #(.W(W), .D(D), .DILATION(DIL)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .inp_v        (inp_v),
        .packed_in    (packed_in),
        .packed_out_a (packed_out_a),
        .packed_out_b (packed_out_b),
        .out_v        (out_v),
        .overrun      (overrun)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_reset;
        rst_n = 1'b0;
        inp_v = 1'b0;
        packed_in = '0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    // Watch n edges; j=0 is the first edge after the call. Records the pulse
    // count, the first pulse offset (-1 if none) and the taps at offset 3.
    task automatic watch(input int n, output int pulses, output int pos,
                         output logic [D*W-1:0] a3, output logic [D*W-1:0] b3);
        pulses = 0;
        pos = -1;
        a3 = '0;
        b3 = '0;
        for (int j = 0; j < n; j++) begin
            @(posedge clk);
            #1;
            if (out_v) begin
                pulses++;
                if (pos < 0) pos = j;
            end
            if (j == 3) begin
                a3 = packed_out_a;
                b3 = packed_out_b;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        inp_v = 1'b0;
        tick(2);
        checks++; if (out_v !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_v: got %b expected 0", out_v); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("[TB] FAIL reset_overrun: got %b expected 0", overrun); end
        checks++; if (packed_out_a !== 32'h0) begin failures++; $display("[TB] FAIL reset_out_a: got %h expected 0", packed_out_a); end
        checks++; if (packed_out_b !== 32'h0) begin failures++; $display("[TB] FAIL reset_out_b: got %h expected 0", packed_out_b); end
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_stream;
        logic [D*W-1:0] s [4];
        logic [D*W-1:0] exp_a [4];
        logic [D*W-1:0] a3, b3;
        int pulses, pos, exp_p, exp_pos;
        s[0] = {16'h1000, 16'hF000};
        s[1] = {16'h2345, 16'hABCD};
        s[2] = {16'h7FFF, 16'h0001};
        s[3] = {16'h8000, 16'h5A5A};
        exp_a[0] = '0;
        exp_a[1] = '0;
        exp_a[2] = s[0];
        exp_a[3] = s[1];
        for (int i = 0; i < 4; i++) begin
            packed_in = s[i];
            inp_v = 1'b0;
            tick(1);
            inp_v = 1'b1;
            watch(15, pulses, pos, a3, b3);
            exp_p = (PRIME && i < DIL) ? 0 : 1;
            exp_pos = (exp_p == 1) ? 3 : -1;
            checks++; if (pulses != exp_p) begin failures++; $display("[TB] FAIL stream%0d_pulses: got %0d expected %0d", i, pulses, exp_p); end
            checks++; if (pos != exp_pos) begin failures++; $display("[TB] FAIL stream%0d_latency: got %0d expected %0d", i, pos, exp_pos); end
            checks++; if (a3 !== exp_a[i]) begin failures++; $display("[TB] FAIL stream%0d_out_a: got %h expected %h", i, a3, exp_a[i]); end
            checks++; if (b3 !== s[i]) begin failures++; $display("[TB] FAIL stream%0d_out_b: got %h expected %h", i, b3, s[i]); end
            checks++; if (packed_out_b !== s[i]) begin failures++; $display("[TB] FAIL stream%0d_out_b_hold: got %h expected %h", i, packed_out_b, s[i]); end
        end
        checks++; if (overrun !== 1'b0) begin failures++; $display("[TB] FAIL stream_overrun: got %b expected 0", overrun); end
    endtask

    task automatic test_hold_high;
        logic [D*W-1:0] a3, b3;
        int pulses, pos;
        apply_reset();
        packed_in = {16'h0ABC, 16'hFFFF};
        tick(7);
        inp_v = 1'b1;
        watch(50, pulses, pos, a3, b3);
        checks++; if (pulses != (PRIME ? 0 : 1)) begin failures++; $display("[TB] FAIL hold_pulses: got %0d expected %0d", pulses, PRIME ? 0 : 1); end
        checks++; if (pos != (PRIME ? -1 : 3)) begin failures++; $display("[TB] FAIL hold_latency: got %0d expected %0d", pos, PRIME ? -1 : 3); end
        checks++; if (b3 !== 32'h0ABCFFFF) begin failures++; $display("[TB] FAIL hold_out_b: got %h expected 0abcffff", b3); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("[TB] FAIL hold_overrun: got %b expected 0", overrun); end
    endtask

    task automatic test_overrun;
        int pulses;
        apply_reset();
        packed_in = {16'h1111, 16'h2222};
        inp_v = 1'b1;
        pulses = 0;
        for (int j = 0; j < 15; j++) begin
            @(posedge clk);
            #1;
            if (out_v) pulses++;
            if (j == 0) inp_v = 1'b0;
            if (j == 1) inp_v = 1'b1;
        end
        checks++; if (pulses != (PRIME ? 0 : 1)) begin failures++; $display("[TB] FAIL overrun_pulses: got %0d expected %0d", pulses, PRIME ? 0 : 1); end
        checks++; if (overrun !== 1'b1) begin failures++; $display("[TB] FAIL overrun_flag: got %b expected 1", overrun); end
        tick(10);
        checks++; if (overrun !== 1'b1) begin failures++; $display("[TB] FAIL overrun_sticky: got %b expected 1", overrun); end
    endtask

    task automatic test_reset_mid;
        logic [D*W-1:0] a3, b3;
        int pulses, pos;
        apply_reset();
        packed_in = {16'h1000, 16'hF000};
        inp_v = 1'b1;
        watch(8, pulses, pos, a3, b3);
        inp_v = 1'b0;
        tick(1);
        packed_in = {16'h3333, 16'h4444};
        inp_v = 1'b1;
        tick(2);
        rst_n = 1'b0;
        #1;
        checks++; if (out_v !== 1'b0) begin failures++; $display("[TB] FAIL midrst_out_v: got %b expected 0", out_v); end
        checks++; if (packed_out_a !== 32'h0) begin failures++; $display("[TB] FAIL midrst_out_a: got %h expected 0", packed_out_a); end
        checks++; if (packed_out_b !== 32'h0) begin failures++; $display("[TB] FAIL midrst_out_b: got %h expected 0", packed_out_b); end
        checks++; if (dut.wr_ptr !== 1'b0) begin failures++; $display("[TB] FAIL midrst_wr_ptr: got %b expected 0", dut.wr_ptr); end
        inp_v = 1'b0;
        tick(2);
        rst_n = 1'b1;
        watch(10, pulses, pos, a3, b3);
        checks++; if (pulses != 0) begin failures++; $display("[TB] FAIL midrst_no_pulse: got %0d expected 0", pulses); end
    endtask

    task automatic test_high_through_reset;
        logic [D*W-1:0] a3, b3;
        int pulses, pos;
        rst_n = 1'b0;
        packed_in = {16'h7FFF, 16'h8000};
        inp_v = 1'b1;
        tick(2);
        rst_n = 1'b1;
        watch(12, pulses, pos, a3, b3);
        checks++; if (pulses != (PRIME ? 0 : 1)) begin failures++; $display("[TB] FAIL rstrel_pulses: got %0d expected %0d", pulses, PRIME ? 0 : 1); end
        checks++; if (pos != (PRIME ? -1 : 3)) begin failures++; $display("[TB] FAIL rstrel_latency: got %0d expected %0d", pos, PRIME ? -1 : 3); end
        checks++; if (b3 !== 32'h7FFF8000) begin failures++; $display("[TB] FAIL rstrel_out_b: got %h expected 7fff8000", b3); end
        checks++; if (a3 !== 32'h0) begin failures++; $display("[TB] FAIL rstrel_out_a: got %h expected 0", a3); end
    endtask

    // Run every scenario in sequence, then report the totals.
    initial begin
        $display("[TB] activation_cache bench start, prime=%0d", PRIME);
        test_reset();
        test_stream();
        test_hold_high();
        test_overrun();
        test_reset_mid();
        test_high_through_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
